// File: rtl/cfi_commit_monitor.sv
// Control-flow-integrity commit monitor: shadow stack plus optional landing-pad check.
// Latency: violation reported 1 cycle after the offending commit; depth/overflow count update on the same edge.
// Backpressure: none; every commit strobe is consumed in the cycle it is presented.
//
// Ports:
//   clk_i, rst_i          single clock, synchronous active-high reset
//   en_i                  monitor enable (0: commits ignored, state holds)
//   flush_i               trap taken; drops any pending landing-pad expectation
//   commit_valid_i/instr_i/pc_i/link_i  per-port retire stream, port 0 oldest
//   violation_o, viol_cause_o, viol_pc_o  registered one-cycle violation report
//   ss_depth_o            live shadow-stack entries
//   ss_ovf_cnt_o          saturating count of entries lost to overflow
//
// Build option: define CFI_LPAD_CHECK_EN to include the landing-pad FSM (cause 10).
module cfi_commit_monitor #(
  parameter int NrCommitPorts = 2,
  parameter int SsDepth       = 16,
  parameter int XLEN          = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  input  logic                                 flush_i,
  input  logic [NrCommitPorts-1:0]             commit_valid_i,
  input  logic [NrCommitPorts-1:0][31:0]       commit_instr_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0]   commit_pc_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0]   commit_link_i,
  output logic                                 violation_o,
  output logic [1:0]                           viol_cause_o,
  output logic [XLEN-1:0]                      viol_pc_o,
  output logic [$clog2(SsDepth):0]             ss_depth_o,
  output logic [15:0]                          ss_ovf_cnt_o
);

  localparam int PW = $clog2(SsDepth);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] DepthFull = DW'(SsDepth);

  localparam logic [1:0] CauseNone      = 2'b00;
  localparam logic [1:0] CauseMismatch  = 2'b01;
  localparam logic [1:0] CauseUnderflow = 2'b11;

  // ---------------------------------------------------------------------------
  // Decoders
  // ---------------------------------------------------------------------------
  function automatic logic is_push(input logic [31:0] ins);
    return (ins == 32'h8210_4073) || (ins == 32'h8250_4073) || (ins[15:0] == 16'h6081);
  endfunction

  function automatic logic is_pop(input logic [31:0] ins);
    return (ins == 32'h81C0_C073) || (ins == 32'h81C2_C073) || (ins[15:0] == 16'h6281);
  endfunction

`ifdef CFI_LPAD_CHECK_EN
  localparam logic [1:0] CauseLpad = 2'b10;

  typedef enum logic {
    LP_IDLE,
    LP_EXPECT
  } lp_state_e;

  function automatic logic is_lpad(input logic [31:0] ins);
    return ins[11:0] == 12'h017;
  endfunction

  // Jumps through x1/x5 are returns covered by the shadow stack, not forward edges.
  function automatic logic is_ijmp(input logic [31:0] ins);
    logic jalr, cjr;
    jalr = (ins[6:0] == 7'h67) && (ins[14:12] == 3'b000) &&
           (ins[19:15] != 5'd1) && (ins[19:15] != 5'd5);
    // C.JR / C.JALR: funct3 100, rs2 = 0, rs1 != 0 (bit 12 selects link or not)
    cjr  = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100) && (ins[6:2] == 5'd0) &&
           (ins[11:7] != 5'd0) && (ins[11:7] != 5'd1) && (ins[11:7] != 5'd5);
    return jalr || cjr;
  endfunction

  lp_state_e lp_q, lp_d;
`else
  // flush only matters to the landing-pad FSM, absent in this build
  logic unused_flush;
  assign unused_flush = flush_i;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ss_q [SsDepth];
  logic [PW-1:0]   wp_q, wp_d;       // next free slot; top of stack is wp_q-1
  logic [DW-1:0]   depth_q, depth_d;
  logic [15:0]     ovf_q, ovf_d;
  logic            viol_q, viol_d;
  logic [1:0]      cause_q, cause_d;
  logic [XLEN-1:0] vpc_q, vpc_d;

  logic [NrCommitPorts-1:0]           wr_en;
  logic [NrCommitPorts-1:0][PW-1:0]   wr_idx;
  logic [NrCommitPorts-1:0][XLEN-1:0] wr_dat;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] top_val;
  logic [1:0]      port_cause;

  // ---------------------------------------------------------------------------
  // Next state: ports are walked oldest first, each seeing the stack as left
  // by the older ports of the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_d       = wp_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    viol_d     = 1'b0;
    cause_d    = CauseNone;
    vpc_d      = '0;
    wr_en      = '0;
    wr_idx     = '0;
    wr_dat     = '0;
    top_idx    = '0;
    top_val    = '0;
    port_cause = CauseNone;
`ifdef CFI_LPAD_CHECK_EN
    lp_d = flush_i ? LP_IDLE : lp_q;
`endif

    if (en_i) begin
      for (int p = 0; p < NrCommitPorts; p++) begin
        port_cause = CauseNone;
        if (commit_valid_i[p]) begin
`ifdef CFI_LPAD_CHECK_EN
          // A flush discards the expectation and any new one from this cycle.
          if (!flush_i) begin
            if (lp_d == LP_EXPECT) begin
              if (!is_lpad(commit_instr_i[p])) port_cause = CauseLpad;
              lp_d = LP_IDLE;
            end
            if (is_ijmp(commit_instr_i[p])) lp_d = LP_EXPECT;
          end
`endif
          if (is_push(commit_instr_i[p])) begin
            wr_en[p]  = 1'b1;
            wr_idx[p] = wp_d;
            wr_dat[p] = commit_link_i[p];
            wp_d      = wp_d + PW'(1);
            // When full, wp_d already points at the oldest entry, so the
            // write above overwrites it.
            if (depth_d == DepthFull) begin
              if (ovf_d != 16'hFFFF) ovf_d = ovf_d + 16'd1;
            end else begin
              depth_d = depth_d + DW'(1);
            end
          end else if (is_pop(commit_instr_i[p])) begin
            if (depth_d == '0) begin
              if (port_cause == CauseNone) port_cause = CauseUnderflow;
            end else begin
              top_idx = wp_d - PW'(1);
              top_val = ss_q[top_idx];
              // Forward pushes from older ports that are not yet in ss_q.
              for (int q = 0; q < p; q++) begin
                if (wr_en[q] && (wr_idx[q] == top_idx)) top_val = wr_dat[q];
              end
              if ((top_val != commit_link_i[p]) && (port_cause == CauseNone))
                port_cause = CauseMismatch;
              wp_d    = top_idx;
              depth_d = depth_d - DW'(1);
            end
          end
          // Only the oldest offending port is reported.
          if ((port_cause != CauseNone) && !viol_d) begin
            viol_d  = 1'b1;
            cause_d = port_cause;
            vpc_d   = commit_pc_i[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= '0;
      viol_q  <= 1'b0;
      cause_q <= CauseNone;
      vpc_q   <= '0;
`ifdef CFI_LPAD_CHECK_EN
      lp_q    <= LP_IDLE;
`endif
    end else begin
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      viol_q  <= viol_d;
      cause_q <= cause_d;
      vpc_q   <= vpc_d;
`ifdef CFI_LPAD_CHECK_EN
      lp_q    <= lp_d;
`endif
    end
  end

  // Stack storage is not reset; depth tracks which entries are meaningful.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (!rst_i && wr_en[p]) ss_q[wr_idx[p]] <= wr_dat[p];
    end
  end

  assign violation_o  = viol_q;
  assign viol_cause_o = cause_q;
  assign viol_pc_o    = vpc_q;
  assign ss_depth_o   = depth_q;
  assign ss_ovf_cnt_o = ovf_q;

endmodule
